// File: rtl/csrs_access_pkg.sv
// csrs_access shared definitions: Zicsr funct3 codes, ALU op codes,
// sequencer states and the read-only CSR address range.
package csrs_access_pkg;

   localparam logic [2:0] CSRRW  = 3'b001;
   localparam logic [2:0] CSRRS  = 3'b010;
   localparam logic [2:0] CSRRC  = 3'b011;
   localparam logic [2:0] CSRRWI = 3'b101;
   localparam logic [2:0] CSRRSI = 3'b110;
   localparam logic [2:0] CSRRCI = 3'b111;

   localparam logic [1:0] OP_RW = 2'b01;
   localparam logic [1:0] OP_RS = 2'b10;
   localparam logic [1:0] OP_RC = 2'b11;

   // addr[11:10] value marking a read-only CSR
   localparam logic [1:0] RO_RANGE = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT_R,
      S_WRITE,
      S_RESP
   } state_t;

   function automatic logic f3_legal(input logic [2:0] f3);
      logic ok;
      case (f3)
         CSRRW, CSRRS, CSRRC,
         CSRRWI, CSRRSI, CSRRCI: ok = 1'b1;
         default:                ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/csrs_access_alu.sv
// csrs_alu: combinational CSR new-value computation.
// Ports: op[1:0] (RW/RS/RC), old_val, src -> new_val.
module csrs_alu
   import csrs_access_pkg::*;
(
   input  logic [1:0]  op,
   input  logic [31:0] old_val,
   input  logic [31:0] src,
   output logic [31:0] new_val
);

   always_comb begin
      new_val = src;
      case (op)
         OP_RW:   new_val = src;
         OP_RS:   new_val = old_val | src;
         OP_RC:   new_val = old_val & ~src;
         default: new_val = src;
      endcase
   end

endmodule

// File: rtl/csrs_access.sv
// csrs_access: Zicsr read-modify-write sequencer in front of the CSR file.
// Ports: REQ_* request in, RDEN/RADDR/RVALID/RDATA read, WREN/WADDR/WDATA
// write, RESP_* response out, FLUSH and synchronous active-high RST.
module csrs_access
   import csrs_access_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic [2:0]  REQ_FUNCT3,
   input  logic [11:0] REQ_ADDR,
   input  logic [4:0]  REQ_RS1,
   input  logic [31:0] REQ_RS1DATA,
   input  logic [4:0]  REQ_RD,
   input  logic        FLUSH,
   output logic        RDEN,
   output logic [11:0] RADDR,
   input  logic        RVALID,
   input  logic [31:0] RDATA,
   output logic        WREN,
   output logic [11:0] WADDR,
   output logic [31:0] WDATA,
   output logic        RESP_VALID,
   input  logic        RESP_READY,
   output logic [4:0]  RESP_RD,
   output logic [31:0] RESP_DATA,
   output logic        RESP_ILLEGAL
);

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [11:0] addr_q, addr_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] src_q, src_d;
   logic        do_wr_q, do_wr_d;
   logic [31:0] old_q, old_d;

   logic        rden_q, rden_d;
   logic [11:0] raddr_q, raddr_d;
   logic        wren_q, wren_d;
   logic [11:0] waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        rvld_q, rvld_d;
   logic [4:0]  rrd_q, rrd_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rill_q, rill_d;

   logic        accept;
   logic [31:0] req_src;
   logic        req_wr;
   logic        req_rd;
   logic        req_ill;
   logic [1:0]  alu_op;
   logic [31:0] alu_old;
   logic [31:0] alu_src;
   logic [31:0] alu_new;

   assign REQ_READY = (state_q == S_IDLE) && !FLUSH && !RST;
   assign accept    = REQ_READY && REQ_VALID;

   // Immediate forms carry zimm in the rs1 field
   assign req_src = REQ_FUNCT3[2] ? {27'b0, REQ_RS1} : REQ_RS1DATA;
   assign req_wr  = (REQ_FUNCT3[1:0] == OP_RW) || (REQ_RS1 != 5'd0);
   assign req_rd  = !((REQ_FUNCT3[1:0] == OP_RW) && (REQ_RD == 5'd0));
   assign req_ill = !f3_legal(REQ_FUNCT3) ||
                    ((REQ_ADDR[11:10] == RO_RANGE) && req_wr);

   // The no-read path computes the write value at accept with old=0
   always_comb begin
      if (state_q == S_IDLE) begin
         alu_op  = REQ_FUNCT3[1:0];
         alu_old = 32'd0;
         alu_src = req_src;
      end else begin
         alu_op  = op_q;
         alu_old = RDATA;
         alu_src = src_q;
      end
   end

   csrs_alu u_alu (
      .op      (alu_op),
      .old_val (alu_old),
      .src     (alu_src),
      .new_val (alu_new)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      src_d   = src_q;
      do_wr_d = do_wr_q;
      old_d   = old_q;
      rden_d  = 1'b0;
      raddr_d = raddr_q;
      wren_d  = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      rvld_d  = rvld_q;
      rrd_d   = rrd_q;
      rdata_d = rdata_q;
      rill_d  = rill_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d    = REQ_FUNCT3[1:0];
               addr_d  = REQ_ADDR;
               rd_d    = REQ_RD;
               src_d   = req_src;
               do_wr_d = req_wr;
               old_d   = 32'd0;
               if (req_ill) begin
                  state_d = S_RESP;
                  rvld_d  = 1'b1;
                  rill_d  = 1'b1;
                  rdata_d = 32'd0;
                  rrd_d   = REQ_RD;
               end else if (req_rd) begin
                  state_d = S_READ;
                  rden_d  = 1'b1;
                  raddr_d = REQ_ADDR;
               end else begin
                  state_d = S_WRITE;
                  wren_d  = req_wr;
                  waddr_d = REQ_ADDR;
                  wdata_d = alu_new;
               end
            end
         end
         S_READ: begin
            state_d = FLUSH ? S_IDLE : S_WAIT_R;
         end
         S_WAIT_R: begin
            if (FLUSH) begin
               state_d = S_IDLE;
            end else if (RVALID) begin
               state_d = S_WRITE;
               old_d   = RDATA;
               wren_d  = do_wr_q;
               waddr_d = addr_q;
               if (do_wr_q) begin
                  wdata_d = alu_new;
               end
            end
         end
         S_WRITE: begin
            state_d = S_RESP;
            rvld_d  = 1'b1;
            rill_d  = 1'b0;
            rdata_d = old_q;
            rrd_d   = rd_q;
         end
         S_RESP: begin
            if (RESP_READY) begin
               state_d = S_IDLE;
               rvld_d  = 1'b0;
               rill_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         op_q    <= 2'd0;
         addr_q  <= 12'd0;
         rd_q    <= 5'd0;
         src_q   <= 32'd0;
         do_wr_q <= 1'b0;
         old_q   <= 32'd0;
         rden_q  <= 1'b0;
         raddr_q <= 12'd0;
         wren_q  <= 1'b0;
         waddr_q <= 12'd0;
         wdata_q <= 32'd0;
         rvld_q  <= 1'b0;
         rrd_q   <= 5'd0;
         rdata_q <= 32'd0;
         rill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         src_q   <= src_d;
         do_wr_q <= do_wr_d;
         old_q   <= old_d;
         rden_q  <= rden_d;
         raddr_q <= raddr_d;
         wren_q  <= wren_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         rvld_q  <= rvld_d;
         rrd_q   <= rrd_d;
         rdata_q <= rdata_d;
         rill_q  <= rill_d;
      end
   end

   assign RDEN         = rden_q;
   assign RADDR        = raddr_q;
   assign WREN         = wren_q;
   assign WADDR        = waddr_q;
   assign WDATA        = wdata_q;
   assign RESP_VALID   = rvld_q;
   assign RESP_RD      = rrd_q;
   assign RESP_DATA    = rdata_q;
   assign RESP_ILLEGAL = rill_q;

endmodule
